// File: rtl/cook_timer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cook_timer_if : keypad / magnetron inputs and display outputs of cook_timer
// Revision      : 1.0
// ---------------------------------------------------------------------------
interface cook_timer_if;
    logic       clrn;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       mag_on;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       timer_done;
    logic       done_pulse;
    logic [1:0] state;

    modport master (
        output clrn, key_valid, key_digit, mag_on,
        input  min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse, state
    );

    modport slave (
        input  clrn, key_valid, key_digit, mag_on,
        output min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse, state
    );
endinterface
`default_nettype wire

// File: rtl/cook_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cook_timer : BCD mm:ss cook-time entry and once-per-second countdown
// Revision   : 1.0
// ---------------------------------------------------------------------------
module cook_timer #(
    parameter int CLK_HZ = 100,
    parameter int CNT_W  = 7
) (
    input  wire logic   clk,
    input  wire logic   rst,
    cook_timer_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CLK_HZ - 1);

    logic [1:0]       cur_state;
    logic [1:0]       nxt_state;
    logic [CNT_W-1:0] presc;
    logic [3:0]       min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic [3:0]       dec_mt, dec_mo, dec_st, dec_so;
    logic             pulse_q;
    logic             running;
    logic             tick;
    logic             key_acc;
    logic             count_zero;
    logic             dec_zero;

    assign count_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                        (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
    assign dec_zero   = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
                        (dec_st == 4'd0) && (dec_so == 4'd0);
    assign tick       = running && (presc == PRESC_LAST);
    // A tick outranks key entry, so a key landing on a tick cycle is dropped.
    assign key_acc    = bus.key_valid && (bus.key_digit <= 4'd9) && !bus.mag_on && !tick;

    // Borrow chain; seconds tens reloads 5 so an entered 6..9 normalises on borrow.
    always_comb begin
        dec_mt = min_tens_q;
        dec_mo = min_ones_q;
        dec_st = sec_tens_q;
        dec_so = sec_ones_q - 4'd1;
        if (sec_ones_q == 4'd0) begin
            dec_so = 4'd9;
            if (sec_tens_q == 4'd0) begin
                dec_st = 4'd5;
                if (min_ones_q == 4'd0) begin
                    dec_mo = 4'd9;
                    dec_mt = min_tens_q - 4'd1;
                end else begin
                    dec_mo = min_ones_q - 4'd1;
                end
            end else begin
                dec_st = sec_tens_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.clrn) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE, DONE: begin
                if (key_acc) nxt_state = ARMED;
            end
            ARMED: begin
                if (bus.mag_on && !count_zero) nxt_state = RUN;
            end
            RUN: begin
                if (tick && dec_zero) nxt_state = DONE;
                else if (!bus.mag_on)  nxt_state = ARMED;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        running   = (cur_state == RUN);
        bus.state = cur_state;
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.clrn) begin
            presc      <= '0;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            pulse_q    <= 1'b0;
        end else begin
            pulse_q <= tick && dec_zero;
            // Outside RUN the prescaler holds, so paused on-time is preserved.
            if (running) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + CNT_W'(1);
            end
            if (tick) begin
                min_tens_q <= dec_mt;
                min_ones_q <= dec_mo;
                sec_tens_q <= dec_st;
                sec_ones_q <= dec_so;
            end else if (key_acc) begin
                min_tens_q <= min_ones_q;
                min_ones_q <= sec_tens_q;
                sec_tens_q <= sec_ones_q;
                sec_ones_q <= bus.key_digit;
            end
        end
    end

    assign bus.min_tens   = min_tens_q;
    assign bus.min_ones   = min_ones_q;
    assign bus.sec_tens   = sec_tens_q;
    assign bus.sec_ones   = sec_ones_q;
    assign bus.timer_done = count_zero;
    assign bus.done_pulse = pulse_q;
endmodule
`default_nettype wire

// File: tb/tb_cook_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cook_timer : directed and random checks of cook_timer against an
//                 arithmetic minutes/seconds model. Revision 1.0
// ---------------------------------------------------------------------------
module tb_cook_timer;
    localparam int CLK_HZ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // Reference model: minutes and seconds as plain integers.
    int   m_min = 0, m_sec = 0, m_state = 0, m_pre = 0;
    bit   m_pulse = 1'b0;
    int   run_cycles = 0;

    cook_timer_if bus ();
    cook_timer #(.CLK_HZ(CLK_HZ), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [19:0] dut_vec;
    assign dut_vec = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
                      bus.timer_done, bus.done_pulse, bus.state};
    logic [15:0] dut_digits;
    assign dut_digits = dut_vec[19:4];

    function automatic logic [19:0] exp_vec();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
                1'(m_min == 0 && m_sec == 0), m_pulse, 2'(m_state)};
    endfunction

    task automatic model_step();
        bit t;
        bit acc;
        if (rst || !bus.clrn) begin
            m_min = 0; m_sec = 0; m_state = 0; m_pre = 0; m_pulse = 1'b0;
            return;
        end
        if (m_state == 2) run_cycles++;
        t = 1'b0;
        m_pulse = 1'b0;
        if (m_state == 2) begin
            if (m_pre == CLK_HZ - 1) begin m_pre = 0; t = 1'b1; end
            else m_pre++;
        end
        if (t) begin
            if (m_sec > 0) m_sec--;
            else begin m_sec = 59; m_min--; end
            if (m_min == 0 && m_sec == 0) begin m_state = 3; m_pulse = 1'b1; end
            else if (!bus.mag_on) m_state = 1;
        end else begin
            acc = bus.key_valid && (bus.key_digit <= 4'd9) && !bus.mag_on;
            case (m_state)
                0, 3: if (acc) m_state = 1;
                1: if (bus.mag_on && (m_min != 0 || m_sec != 0)) m_state = 2;
                2: if (!bus.mag_on) m_state = 1;
                default: m_state = 0;
            endcase
            if (acc) begin
                m_min = (m_min % 10) * 10 + m_sec / 10;
                m_sec = (m_sec % 10) * 10 + int'(bus.key_digit);
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        cyc();
        bus.key_valid = 1'b0;
    endtask

    task automatic do_clear();
        bus.clrn = 1'b0;
        cyc();
        bus.clrn = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        if (dut_vec !== {16'h0000, 1'b1, 1'b0, 2'd0}) begin
            errors++; $display("FAIL reset: got %h want %h", dut_vec, {16'h0000, 1'b1, 1'b0, 2'd0});
        end
        checks++;
    endtask

    task automatic test_basic();
        do_clear();
        press(4'd1); press(4'd3); press(4'd0);
        if (dut_vec !== {16'h0130, 1'b0, 1'b0, 2'd1}) begin
            errors++; $display("FAIL basic_load: got %h want %h", dut_vec, {16'h0130, 1'b0, 1'b0, 2'd1});
        end
        checks++;
        bus.mag_on = 1'b1;
        cyc();
        run_cycles = 0;
        repeat (4) cyc();
        if (dut_digits !== 16'h0129) begin
            errors++; $display("FAIL basic_first_tick: got %h want 0129", dut_digits);
        end
        checks++;
        for (int i = 0; i < 400 && !m_pulse; i++) begin
            cyc();
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL basic_count: got %h want %h", dut_vec, exp_vec());
            end
            checks++;
        end
        if (!m_pulse || dut_vec !== {16'h0000, 1'b1, 1'b1, 2'd3}) begin
            errors++; $display("FAIL basic_expiry: got %h want %h", dut_vec, {16'h0000, 1'b1, 1'b1, 2'd3});
        end
        checks++;
        if (run_cycles != 360) begin
            errors++; $display("FAIL basic_on_time: got %0d want 360", run_cycles);
        end
        checks++;
        cyc();
        if (bus.done_pulse !== 1'b0 || bus.state !== 2'd3) begin
            errors++; $display("FAIL basic_pulse_width: got pulse=%b state=%0d want 0/3",
                               bus.done_pulse, bus.state);
        end
        checks++;
        bus.mag_on = 1'b0;
        cyc();
    endtask

    task automatic test_pause();
        do_clear();
        press(4'd5);
        bus.mag_on = 1'b1;
        cyc();
        run_cycles = 0;
        repeat (6) cyc();
        if (dut_digits !== 16'h0004) begin
            errors++; $display("FAIL pause_pre: got %h want 0004", dut_digits);
        end
        checks++;
        bus.mag_on = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (dut_digits !== 16'h0004 || bus.state !== 2'd1) begin
                errors++; $display("FAIL pause_hold: got %h state=%0d want 0004 state=1",
                                   dut_digits, bus.state);
            end
            checks++;
        end
        bus.mag_on = 1'b1;
        for (int i = 0; i < 40 && !m_pulse; i++) begin
            cyc();
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL pause_resume: got %h want %h", dut_vec, exp_vec());
            end
            checks++;
        end
        if (!m_pulse || run_cycles != 20 || bus.done_pulse !== 1'b1) begin
            errors++; $display("FAIL pause_on_time: got run=%0d pulse=%b want 20/1",
                               run_cycles, bus.done_pulse);
        end
        checks++;
        bus.mag_on = 1'b0;
        cyc();
    endtask

    task automatic test_borrow();
        do_clear();
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        bus.mag_on = 1'b1;
        cyc();
        repeat (4) cyc();
        if (dut_digits !== 16'h0959) begin
            errors++; $display("FAIL borrow_minute: got %h want 0959", dut_digits);
        end
        checks++;
        bus.mag_on = 1'b0;
        cyc();
        do_clear();
        press(4'd6); press(4'd0);
        if (dut_digits !== 16'h0060) begin
            errors++; $display("FAIL borrow_load60: got %h want 0060", dut_digits);
        end
        checks++;
        bus.mag_on = 1'b1;
        cyc();
        repeat (4) cyc();
        if (dut_digits !== 16'h0059 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL borrow_sec60: got %h want 0059", dut_digits);
        end
        checks++;
        bus.mag_on = 1'b0;
        cyc();
    endtask

    task automatic test_ignore();
        press(4'hA);
        if (dut_digits !== 16'h0059 || bus.state !== 2'd1) begin
            errors++; $display("FAIL ignore_bad_digit: got %h state=%0d want 0059 state=1",
                               dut_digits, bus.state);
        end
        checks++;
        bus.mag_on = 1'b1;
        press(4'd7);
        press(4'd7);
        if (dut_digits !== 16'h0059 || bus.state !== 2'd2) begin
            errors++; $display("FAIL ignore_while_on: got %h state=%0d want 0059 state=2",
                               dut_digits, bus.state);
        end
        checks++;
        bus.mag_on = 1'b0;
        cyc();
    endtask

    task automatic test_clear();
        do_clear();
        press(4'd3);
        bus.mag_on = 1'b1;
        cyc();
        repeat (2) cyc();
        bus.clrn = 1'b0;
        cyc();
        bus.clrn = 1'b1;
        if (dut_vec !== {16'h0000, 1'b1, 1'b0, 2'd0}) begin
            errors++; $display("FAIL clear: got %h want %h", dut_vec, {16'h0000, 1'b1, 1'b0, 2'd0});
        end
        checks++;
        repeat (6) cyc();
        if (bus.state !== 2'd0 || bus.done_pulse !== 1'b0 || bus.timer_done !== 1'b1) begin
            errors++; $display("FAIL clear_zero_run: got state=%0d pulse=%b done=%b want 0/0/1",
                               bus.state, bus.done_pulse, bus.timer_done);
        end
        checks++;
        bus.mag_on = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bus.clrn      = ($urandom_range(0, 99) != 0);
            bus.key_valid = ($urandom_range(0, 3) == 0);
            bus.key_digit = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 11) == 0) bus.mag_on = ~bus.mag_on;
            cyc();
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
            checks++;
        end
        bus.clrn      = 1'b1;
        bus.key_valid = 1'b0;
        bus.mag_on    = 1'b0;
    endtask

    initial begin
        bus.clrn      = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
        bus.mag_on    = 1'b0;
        test_reset();
        test_basic();
        test_pause();
        test_borrow();
        test_ignore();
        test_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
